// File: rtl/mem_lsu_seq_pkg.sv
// Shared definitions for the sequential load/store unit:
// op_i encodings, exception codes, FSM state encoding and decode helpers.
package mem_lsu_seq_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8,
    OP_LL   = 4'd9,
    OP_SC   = 4'd10
  } op_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_store(input op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
  endfunction

  function automatic logic is_misaligned(input op_e op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH:               return a[0];
      OP_LW, OP_SW, OP_LL, OP_SC:         return a != 2'b00;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering, big-endian lanes (address 00 = [31:24]).
//   i_op       effective memory op
//   i_addr_lo  address bits [1:0]
//   i_wdata    store data (rt)
//   i_rdata    raw bus read word
//   o_sel      byte enables, bit3 = lane [31:24]
//   o_wdata    lane-replicated store data
//   o_ldata    extracted and sign/zero-extended load result
module mem_lane_align
  import mem_lsu_seq_pkg::*;
(
  input  op_e         i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
  end

  always_comb begin
    o_sel   = 4'b1111;   // reads and word stores use all lanes
    o_wdata = i_wdata;
    o_ldata = 32'd0;
    case (i_op)
      OP_SB: begin
        o_sel   = 4'b1000 >> i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      OP_SH: begin
        o_sel   = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_wdata = {2{i_wdata[15:0]}};
      end
      OP_LB:        o_ldata = {{24{w_byte[7]}}, w_byte};
      OP_LBU:       o_ldata = {24'd0, w_byte};
      OP_LH:        o_ldata = {{16{w_half[15]}}, w_half};
      OP_LHU:       o_ldata = {16'd0, w_half};
      OP_LW, OP_LL: o_ldata = i_rdata;
      default:      ;
    endcase
  end

endmodule

// File: rtl/mem_lsu_seq.sv
// Sequential MEM-stage load/store unit on a handshaked data bus.
// Handles lane steering, LL/SC with an internal llbit, misalignment
// exceptions, bus errors and a watchdog timeout; stalls the pipe while busy.
//   valid_i/op_i/addr_i/wdata_i  MEM-stage request (held while stall_req_o)
//   flush_i, llbit_clr_i         pipeline control
//   stall_req_o                  stall toward ctrl
//   result_valid_o, rdata_o, excep_code_o, bad_addr_o, llbit_o  to MEM/WB
//   bus_*                        data bus master side
module mem_lsu_seq
  import mem_lsu_seq_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter bit LL_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  input  logic              llbit_clr_i,
  output logic              stall_req_o,
  output logic              result_valid_o,
  output logic [31:0]       rdata_o,
  output logic [4:0]        excep_code_o,
  output logic [ADDR_W-1:0] bad_addr_o,
  output logic              llbit_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  output logic [3:0]        bus_sel_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [31:0]       bus_rdata_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            r_state;
  op_e               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [CW-1:0]     r_cnt;
  logic              r_llbit;
  logic [31:0]       r_rdata;
  logic [4:0]        r_exc;
  logic [ADDR_W-1:0] r_bad;
  logic              r_bus_req, r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_sel;

  op_e         w_op, w_al_op;
  logic [1:0]  w_al_addr;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata, w_ldata;
  logic        w_accept, w_misal, w_store, w_tmo, w_busy, w_drop;

  // With LL/SC disabled the ops fall back to plain word accesses.
  always_comb begin
    w_op = op_e'(op_i);
    if (!LL_EN && w_op == OP_LL) w_op = OP_LW;
    if (!LL_EN && w_op == OP_SC) w_op = OP_SW;
  end

  assign w_accept = (r_state == ST_IDLE) && valid_i && (op_i != 4'd0) && !flush_i;
  assign w_misal  = is_misaligned(w_op, addr_i[1:0]);
  assign w_store  = is_store(w_op);
  assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));
  assign w_busy   = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
  assign w_drop   = w_busy && (bus_ack_i || bus_err_i || w_tmo);

  // One aligner serves both directions: in IDLE it builds the store from the
  // live request, afterwards it extracts the load from the captured op/addr.
  assign w_al_op   = (r_state == ST_IDLE) ? w_op : r_op;
  assign w_al_addr = (r_state == ST_IDLE) ? addr_i[1:0] : r_addr[1:0];

  mem_lane_align u_align (
    .i_op      (w_al_op),
    .i_addr_lo (w_al_addr),
    .i_wdata   (wdata_i),
    .i_rdata   (bus_rdata_i),
    .o_sel     (w_sel),
    .o_wdata   (w_wdata),
    .o_ldata   (w_ldata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NONE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_llbit     <= 1'b0;
      r_rdata     <= '0;
      r_exc       <= EXC_NONE;
      r_bad       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_sel   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op   <= w_op;
          r_addr <= addr_i;
          if (w_misal) begin
            r_state <= ST_DONE;
            r_exc   <= w_store ? EXC_ADES : EXC_ADEL;
            r_bad   <= addr_i;
            r_rdata <= '0;
          end else if (w_op == OP_SC && !r_llbit) begin
            r_state <= ST_DONE;   // SC fails locally, bus untouched
            r_exc   <= EXC_NONE;
            r_rdata <= '0;
          end else begin
            r_state     <= ST_WAIT;
            r_cnt       <= '0;
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_store;
            r_bus_addr  <= {addr_i[ADDR_W-1:2], 2'b00};
            r_bus_sel   <= w_sel;
            r_bus_wdata <= w_wdata;
          end
        end
        ST_WAIT: begin
          if (bus_err_i || (!bus_ack_i && w_tmo)) begin
            r_state <= ST_DONE;
            r_exc   <= EXC_DBE;
            r_bad   <= r_addr;
            r_rdata <= '0;
          end else if (bus_ack_i) begin
            r_state <= ST_DONE;
            r_exc   <= EXC_NONE;
            if (r_op == OP_SC)        r_rdata <= 32'd1;
            else if (is_store(r_op))  r_rdata <= '0;
            else                      r_rdata <= w_ldata;
            if (r_op == OP_LL) r_llbit <= 1'b1;
            if (r_op == OP_SC) r_llbit <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (flush_i) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus_ack_i || bus_err_i || w_tmo) r_state <= ST_IDLE;
          else                                 r_cnt   <= r_cnt + 1'b1;
        end
        default: begin   // ST_DONE
          r_state <= ST_IDLE;
          r_rdata <= '0;
          r_exc   <= EXC_NONE;
          r_bad   <= '0;
        end
      endcase
      if (w_drop) begin
        r_bus_req   <= 1'b0;
        r_bus_we    <= 1'b0;
        r_bus_addr  <= '0;
        r_bus_sel   <= '0;
        r_bus_wdata <= '0;
      end
      // Explicit clear wins over an LL completing in the same cycle.
      if (llbit_clr_i || !LL_EN) r_llbit <= 1'b0;
    end
  end

  assign stall_req_o    = w_accept || w_busy;
  assign result_valid_o = (r_state == ST_DONE) && !flush_i;
  assign rdata_o        = r_rdata;
  assign excep_code_o   = r_exc;
  assign bad_addr_o     = r_bad;
  assign llbit_o        = r_llbit;
  assign bus_req_o      = r_bus_req;
  assign bus_we_o       = r_bus_we;
  assign bus_addr_o     = r_bus_addr;
  assign bus_wdata_o    = r_bus_wdata;
  assign bus_sel_o      = r_bus_sel;

endmodule

// File: tb/tb_mem_lsu_seq.sv
module tb_mem_lsu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [3:0]  op_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        flush_i = 1'b0;
  logic        llbit_clr_i = 1'b0;
  logic        stall_req_o, result_valid_o, llbit_o;
  logic [31:0] rdata_o, bad_addr_o, bus_addr_o, bus_wdata_o;
  logic [4:0]  excep_code_o;
  logic        bus_req_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i = 1'b0, bus_err_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  mem_lsu_seq #(.ADDR_W(32), .TIMEOUT(8), .LL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .flush_i(flush_i), .llbit_clr_i(llbit_clr_i),
    .stall_req_o(stall_req_o), .result_valid_o(result_valid_o), .rdata_o(rdata_o),
    .excep_code_o(excep_code_o), .bad_addr_o(bad_addr_o), .llbit_o(llbit_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o), .bus_ack_i(bus_ack_i),
    .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic [4:0]  exc;
    logic [31:0] bad;
    logic        ll;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  // Monitor: every result pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (result_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got rdata 0x%08h exc %0d with nothing expected",
                 rdata_o, excep_code_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".rdata"}, rdata_o, e.rdata);
        chk({e.name, ".exc"}, {27'd0, excep_code_o}, {27'd0, e.exc});
        chk({e.name, ".bad"}, bad_addr_o, e.bad);
        chk({e.name, ".llbit"}, {31'd0, llbit_o}, {31'd0, e.ll});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // resp: 0 = ack, 1 = err+ack together, 2 = never respond (timeout)
  task automatic do_op(input string n, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input bit bus, input int waits, input int resp,
                       input logic [31:0] rd, input logic [31:0] e_baddr, input logic [3:0] e_sel,
                       input logic e_we, input logic [31:0] e_bwd,
                       input logic [31:0] x_rd, input logic [4:0] x_exc,
                       input logic [31:0] x_bad, input logic x_ll);
    exp_t e;
    int   n_cyc;
    e.name = n; e.rdata = x_rd; e.exc = x_exc; e.bad = x_bad; e.ll = x_ll;
    exp_q.push_back(e);
    valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd;
    #1 chk({n, ".stall_t0"}, {31'd0, stall_req_o}, 32'd1);
    tick();                                   // T1
    if (!bus) begin
      chk({n, ".noreq"}, {31'd0, bus_req_o}, 32'd0);
      chk({n, ".rv_t1"}, {31'd0, result_valid_o}, 32'd1);
      chk({n, ".stall_done"}, {31'd0, stall_req_o}, 32'd0);
      valid_i = 1'b0;
      tick();
      return;
    end
    chk({n, ".req"}, {31'd0, bus_req_o}, 32'd1);
    chk({n, ".stall_t1"}, {31'd0, stall_req_o}, 32'd1);
    chk({n, ".baddr"}, bus_addr_o, e_baddr);
    chk({n, ".sel"}, {28'd0, bus_sel_o}, {28'd0, e_sel});
    chk({n, ".we"}, {31'd0, bus_we_o}, {31'd0, e_we});
    if (e_we) chk({n, ".bwdata"}, bus_wdata_o, e_bwd);
    if (resp == 2) begin
      n_cyc = 0;
      while (result_valid_o !== 1'b1 && n_cyc < 30) begin tick(); n_cyc++; end
      chk({n, ".timeout_cycles"}, n_cyc, 32'd8);
    end else begin
      for (int i = 0; i < waits; i++) tick();
      chk({n, ".req_held"}, {31'd0, bus_req_o}, 32'd1);
      bus_rdata_i = rd; bus_ack_i = 1'b1; bus_err_i = (resp == 1);
      tick();                                 // DONE
      bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
      chk({n, ".rv"}, {31'd0, result_valid_o}, 32'd1);
      chk({n, ".req_drop"}, {31'd0, bus_req_o}, 32'd0);
    end
    chk({n, ".stall_done"}, {31'd0, stall_req_o}, 32'd0);
    valid_i = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    chk("reset.stall", {31'd0, stall_req_o}, 32'd0);
    chk("reset.rv", {31'd0, result_valid_o}, 32'd0);
    chk("reset.req", {31'd0, bus_req_o}, 32'd0);
    chk("reset.llbit", {31'd0, llbit_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    //     name        op      addr         wdata       bus w  r rd            baddr        sel      we  bwd           xrd           exc  bad          ll
    do_op("lb",        4'd1,  32'h1003, 32'h0,        1, 0, 0, 32'h11223380, 32'h1000, 4'b1111, 0, 32'h0,        32'hFFFFFF80, 5'd0, 32'h0,    0);
    do_op("sh",        4'd7,  32'h2002, 32'h0000BEEF, 1, 3, 0, 32'h0,        32'h2000, 4'b0011, 1, 32'hBEEFBEEF, 32'h0,        5'd0, 32'h0,    0);
    do_op("lw_mis",    4'd5,  32'h3001, 32'h0,        0, 0, 0, 32'h0,        32'h0,    4'b0000, 0, 32'h0,        32'h0,        5'd4, 32'h3001, 0);
    do_op("sw_mis",    4'd8,  32'h3002, 32'h0,        0, 0, 0, 32'h0,        32'h0,    4'b0000, 0, 32'h0,        32'h0,        5'd5, 32'h3002, 0);
    do_op("lh_mis",    4'd3,  32'h1001, 32'h0,        0, 0, 0, 32'h0,        32'h0,    4'b0000, 0, 32'h0,        32'h0,        5'd4, 32'h1001, 0);
    do_op("lbu",       4'd2,  32'h1000, 32'h0,        1, 1, 0, 32'h80FF0000, 32'h1000, 4'b1111, 0, 32'h0,        32'h00000080, 5'd0, 32'h0,    0);
    do_op("lh",        4'd3,  32'h1002, 32'h0,        1, 0, 0, 32'h12348001, 32'h1000, 4'b1111, 0, 32'h0,        32'hFFFF8001, 5'd0, 32'h0,    0);
    do_op("lhu",       4'd4,  32'h1000, 32'h0,        1, 0, 0, 32'h80010000, 32'h1000, 4'b1111, 0, 32'h0,        32'h00008001, 5'd0, 32'h0,    0);
    do_op("sb",        4'd6,  32'h1001, 32'h000000AB, 1, 0, 0, 32'h0,        32'h1000, 4'b0100, 1, 32'hABABABAB, 32'h0,        5'd0, 32'h0,    0);
    do_op("ll",        4'd9,  32'h0040, 32'h0,        1, 0, 0, 32'hCAFE0000, 32'h0040, 4'b1111, 0, 32'h0,        32'hCAFE0000, 5'd0, 32'h0,    1);
    do_op("sc_ok",     4'd10, 32'h0040, 32'h00000055, 1, 1, 0, 32'h0,        32'h0040, 4'b1111, 1, 32'h00000055, 32'h1,        5'd0, 32'h0,    0);
    do_op("ll2",       4'd9,  32'h0044, 32'h0,        1, 0, 0, 32'h7,        32'h0044, 4'b1111, 0, 32'h0,        32'h7,        5'd0, 32'h0,    1);
    llbit_clr_i = 1'b1; tick(); llbit_clr_i = 1'b0;
    chk("llclr.llbit", {31'd0, llbit_o}, 32'd0);
    do_op("sc_fail",   4'd10, 32'h0044, 32'h1,        0, 0, 0, 32'h0,        32'h0,    4'b0000, 0, 32'h0,        32'h0,        5'd0, 32'h0,    0);
    do_op("sc_mis",    4'd10, 32'h0042, 32'h1,        0, 0, 0, 32'h0,        32'h0,    4'b0000, 0, 32'h0,        32'h0,        5'd5, 32'h0042, 0);
    do_op("tmo",       4'd5,  32'h0100, 32'h0,        1, 0, 2, 32'h0,        32'h0100, 4'b1111, 0, 32'h0,        32'h0,        5'd7, 32'h0100, 0);
    do_op("err_ack",   4'd5,  32'h0104, 32'h0,        1, 1, 1, 32'hDEADBEEF, 32'h0104, 4'b1111, 0, 32'h0,        32'h0,        5'd7, 32'h0104, 0);

    // Flush while waiting: bus finishes two cycles later, no result.
    valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h5000;
    tick();
    chk("flush.req", {31'd0, bus_req_o}, 32'd1);
    flush_i = 1'b1; valid_i = 1'b0;
    tick(); flush_i = 1'b0;
    chk("flush.drain_stall", {31'd0, stall_req_o}, 32'd1);
    chk("flush.drain_req", {31'd0, bus_req_o}, 32'd1);
    tick();
    chk("flush.drain_stall2", {31'd0, stall_req_o}, 32'd1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h99999999;
    tick(); bus_ack_i = 1'b0; bus_rdata_i = '0;
    chk("flush.idle_stall", {31'd0, stall_req_o}, 32'd0);
    chk("flush.idle_req", {31'd0, bus_req_o}, 32'd0);
    do_op("after_flush", 4'd2, 32'h1002, 32'h0, 1, 0, 0, 32'h0000AB00, 32'h1000, 4'b1111, 0, 32'h0, 32'h000000AB, 5'd0, 32'h0, 0);

    // Reset mid-access with llbit set.
    do_op("ll3",       4'd9,  32'h6000, 32'h0,        1, 0, 0, 32'h1,        32'h6000, 4'b1111, 0, 32'h0,        32'h1,        5'd0, 32'h0,    1);
    valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h6004;
    tick();
    chk("rst.req_before", {31'd0, bus_req_o}, 32'd1);
    rst_n = 1'b0; valid_i = 1'b0;
    tick();
    chk("rst.req", {31'd0, bus_req_o}, 32'd0);
    chk("rst.stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst.baddr", bus_addr_o, 32'h0);
    chk("rst.llbit", {31'd0, llbit_o}, 32'd0);
    chk("rst.rdata", rdata_o, 32'h0);
    rst_n = 1'b1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h55555555;
    tick(); bus_ack_i = 1'b0; bus_rdata_i = '0;
    chk("rst.late_ack_req", {31'd0, bus_req_o}, 32'd0);
    tick();
    do_op("after_rst", 4'd5,  32'h6008, 32'h0,        1, 2, 0, 32'h12345678, 32'h6008, 4'b1111, 0, 32'h0,        32'h12345678, 5'd0, 32'h0,    0);

    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
